// File: rtl/multiplier_sequential_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Holds the FSM state encoding, the default operand width and width-agnostic
// two's-complement helpers that callers size-cast down to their own width.
package multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 16;

    // Widest operand the helpers cover; products use twice this.
    localparam int MAX_W  = 64;
    localparam int MAX_PW = 2 * MAX_W;

    // Bit-counter width: enough to count 0..w-1, never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

    // Unsigned magnitude of a w-bit operand held zero-extended in val. Only the
    // low w bits of the return are meaningful; -2^(w-1) maps to 2^(w-1).
    function automatic logic [MAX_W-1:0] magnitude(input logic [MAX_W-1:0] val,
                                                   input int w,
                                                   input logic is_signed);
        if (is_signed && val[w-1])
            return ~val + 1'b1;
        return val;
    endfunction

    // Two's-complement negation; callers keep the low bits they need.
    function automatic logic [MAX_PW-1:0] negate(input logic [MAX_PW-1:0] val);
        return ~val + 1'b1;
    endfunction

endpackage

// File: rtl/multiplier_sequential_if.sv
// Operand/result handshake bundle for the sequential multiplier.
// slave = multiplier side, master = producer/consumer side.
// Widths follow the WIDTH parameter, which must match the attached multiplier.
interface multiplier_sequential_if
    import multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0]   Data_A_In;
    logic [WIDTH-1:0]   Data_B_In;
    logic               Signed_Mode_In;
    logic               In_Valid_In;
    logic               In_Ready_Out;
    logic [2*WIDTH-1:0] Multiplied_Result_Out;
    logic               Out_Valid_Out;
    logic               Out_Ready_In;

    modport slave (
        input  Data_A_In,
        input  Data_B_In,
        input  Signed_Mode_In,
        input  In_Valid_In,
        input  Out_Ready_In,
        output In_Ready_Out,
        output Multiplied_Result_Out,
        output Out_Valid_Out
    );

    modport master (
        output Data_A_In,
        output Data_B_In,
        output Signed_Mode_In,
        output In_Valid_In,
        output Out_Ready_In,
        input  In_Ready_Out,
        input  Multiplied_Result_Out,
        input  Out_Valid_Out
    );

endinterface

// File: rtl/multiplier_sequential.sv
// Shift-add multiplier, signed or unsigned per operation, one operation in flight (WIDTH 2..64).
// Latency: WIDTH cycles from accept edge to Out_Valid_Out; one product per WIDTH+2 cycles at best.
// Backpressure: DONE holds result and valid until Out_Ready_In; operands are taken only in IDLE.
module multiplier_sequential
    import multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)
(
    input  logic                   Clock_In,
    input  logic                   Reset_n_In,
    multiplier_sequential_if.slave bus
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    result;
    logic             sign;
    logic             in_ready;
    logic             out_valid;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PW-1:0]    sum;

    // Operand magnitudes for the accept edge and the next partial sum.
    always_comb begin
        a_mag = WIDTH'(magnitude(MAX_W'(bus.Data_A_In), WIDTH, bus.Signed_Mode_In));
        b_mag = WIDTH'(magnitude(MAX_W'(bus.Data_B_In), WIDTH, bus.Signed_Mode_In));
        sum   = acc + (mplier[0] ? mcand : '0);
    end

    // Control FSM and datapath; handshake outputs are registered so they never
    // depend combinationally on In_Valid_In or Out_Ready_In.
    always_ff @(posedge Clock_In) begin
        if (!Reset_n_In) begin
            state     <= IDLE;
            count     <= '0;
            mplier    <= '0;
            mcand     <= '0;
            acc       <= '0;
            result    <= '0;
            sign      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.In_Valid_In) begin
                        mcand    <= PW'(a_mag);
                        mplier   <= b_mag;
                        sign     <= bus.Signed_Mode_In &
                                    (bus.Data_A_In[WIDTH-1] ^ bus.Data_B_In[WIDTH-1]);
                        acc      <= '0;
                        count    <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    // Fixed WIDTH iterations: no early exit on a zero multiplier.
                    acc    <= sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        result    <= sign ? PW'(negate(MAX_PW'(sum))) : sum;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.Out_Ready_In) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.In_Ready_Out          = in_ready;
    assign bus.Out_Valid_Out         = out_valid;
    assign bus.Multiplied_Result_Out = result;

endmodule

// File: tb/tb_multiplier_sequential.sv
// Directed bench for multiplier_sequential at WIDTH 16, plus 4- and 32-bit sweeps.
// Inputs change and outputs are sampled on the falling clock edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_multiplier_sequential;
    import multiplier_pkg::*;

    logic clk;
    logic rst16_n;
    logic rst_sw_n;

    int tests  = 0;
    int failed = 0;

    multiplier_sequential_if #(.WIDTH(16)) i16 ();
    multiplier_sequential_if #(.WIDTH(4))  i4  ();
    multiplier_sequential_if #(.WIDTH(32)) i32 ();

    multiplier_sequential #(.WIDTH(16)) dut16 (.Clock_In(clk), .Reset_n_In(rst16_n),  .bus(i16));
    multiplier_sequential #(.WIDTH(4))  dut4  (.Clock_In(clk), .Reset_n_In(rst_sw_n), .bus(i4));
    multiplier_sequential #(.WIDTH(32)) dut32 (.Clock_In(clk), .Reset_n_In(rst_sw_n), .bus(i32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic vld, input logic [31:0] a,
                          input logic [31:0] b, input logic m);
        case (sel)
            0: begin i16.In_Valid_In = vld; i16.Data_A_In = a[15:0]; i16.Data_B_In = b[15:0]; i16.Signed_Mode_In = m; end
            1: begin i4.In_Valid_In  = vld; i4.Data_A_In  = a[3:0];  i4.Data_B_In  = b[3:0];  i4.Signed_Mode_In  = m; end
            default: begin i32.In_Valid_In = vld; i32.Data_A_In = a; i32.Data_B_In = b; i32.Signed_Mode_In = m; end
        endcase
    endtask

    task automatic set_ordy(input int sel, input logic v);
        case (sel)
            0:       i16.Out_Ready_In = v;
            1:       i4.Out_Ready_In  = v;
            default: i32.Out_Ready_In = v;
        endcase
    endtask

    function automatic logic get_irdy(input int sel);
        case (sel)
            0:       return i16.In_Ready_Out;
            1:       return i4.In_Ready_Out;
            default: return i32.In_Ready_Out;
        endcase
    endfunction

    function automatic logic get_ovld(input int sel);
        case (sel)
            0:       return i16.Out_Valid_Out;
            1:       return i4.Out_Valid_Out;
            default: return i32.Out_Valid_Out;
        endcase
    endfunction

    function automatic logic [63:0] get_res(input int sel);
        case (sel)
            0:       return {32'b0, i16.Multiplied_Result_Out};
            1:       return {56'b0, i4.Multiplied_Result_Out};
            default: return i32.Multiplied_Result_Out;
        endcase
    endfunction

    // Reference product: exact integer multiply, kept to 2*w bits.
    function automatic logic [63:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic m);
        logic [63:0] mask_w, mask_p, ua, ub, p;
        longint sa, sb;
        mask_w = (w == 32) ? 64'hFFFF_FFFF : ((64'd1 << w) - 64'd1);
        mask_p = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
        ua = {32'b0, a} & mask_w;
        ub = {32'b0, b} & mask_w;
        if (m) begin
            sa = longint'(ua);
            sb = longint'(ub);
            if (ua[w-1]) sa = sa - (longint'(1) << w);
            if (ub[w-1]) sb = sb - (longint'(1) << w);
            p = 64'(sa * sb);
        end else begin
            p = ua * ub;
        end
        return p & mask_p;
    endfunction

    // One full operation: wait for ready, accept, measure latency, check result,
    // optionally hold Out_Ready_In low for 'hold' cycles, then confirm return to IDLE.
    task automatic run_op(input int sel, input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic m, input logic [63:0] exp, input string tag, input int hold);
        int n;
        int lat;
        bit stable;
        logic [63:0] held;
        set_ordy(sel, hold == 0);
        n = 0;
        while (!get_irdy(sel) && n < 200) begin
            @(posedge clk); @(negedge clk); n++;
        end
        check({tag, "_rdy"}, 64'(get_irdy(sel)), 64'd1);
        set_in(sel, 1'b1, a, b, m);
        @(posedge clk); @(negedge clk);
        set_in(sel, 1'b0, 32'h0, 32'h0, 1'b0);
        lat = 0;
        while (!get_ovld(sel) && lat < w + 20) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(w));
        check({tag, "_res"}, get_res(sel), exp);
        if (hold > 0) begin
            stable = 1'b1;
            held   = get_res(sel);
            repeat (hold) begin
                @(posedge clk); @(negedge clk);
                if (!get_ovld(sel) || get_irdy(sel) || get_res(sel) !== held) stable = 1'b0;
            end
            check({tag, "_bp"}, 64'(stable), 64'd1);
            set_ordy(sel, 1'b1);
        end
        @(posedge clk); @(negedge clk);
        check({tag, "_idle"}, {62'b0, get_irdy(sel), get_ovld(sel)}, 64'b10);
    endtask

    logic [15:0] ba [4] = '{16'd3, 16'hFFFE, 16'h1234, 16'h7FFF};
    logic [15:0] bb [4] = '{16'd5, 16'd3,    16'h0010, 16'h8000};
    logic        bm [4] = '{1'b0,  1'b1,     1'b0,     1'b1};
    logic [63:0] be [4] = '{64'd15, 64'hFFFF_FFFA, 64'h0001_2340, 64'hC000_8000};

    initial begin
        int nin, nout, cyc;
        bit took;
        int acc_cyc [4];
        logic [31:0] ra, rb;
        logic rm;

        rst16_n  = 1'b0;
        rst_sw_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            set_in(s, 1'b0, 32'h0, 32'h0, 1'b0);
            set_ordy(s, 1'b1);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_irdy", 64'(i16.In_Ready_Out), 64'd1);
        check("rst_ovld", 64'(i16.Out_Valid_Out), 64'd0);
        check("rst_res",  get_res(0), 64'd0);
        check("rst_sw_ovld", {62'b0, i4.Out_Valid_Out, i32.Out_Valid_Out}, 64'd0);
        rst16_n  = 1'b1;
        rst_sw_n = 1'b1;

        // Directed products at WIDTH 16
        run_op(0, 16, 32'd300,   32'd7,      1'b0, 64'd2100,        "u_basic", 0);
        run_op(0, 16, 32'h8000,  32'h8000,   1'b1, 64'h4000_0000,   "s_minsq", 0);
        run_op(0, 16, 32'hFFFF,  32'h0002,   1'b1, 64'hFFFF_FFFE,   "s_neg1x2", 0);
        run_op(0, 16, 32'hFFFF,  32'h0002,   1'b0, 64'h0001_FFFE,   "u_ffffx2", 0);
        run_op(0, 16, 32'hFFFF,  32'hFFFF,   1'b1, 64'd1,           "s_neg1sq", 0);
        run_op(0, 16, 32'hFFFF,  32'hFFFF,   1'b0, 64'hFFFE_0001,   "u_maxsq", 0);
        run_op(0, 16, 32'd25,    32'd4,      1'b0, 64'd100,         "bp", 10);
        run_op(1, 4,  32'h8,     32'h8,      1'b1, 64'h40,          "w4_minsq", 0);
        run_op(2, 32, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "w32_minsq", 0);

        // Back-to-back stream with In_Valid_In held high
        nin  = 0;
        nout = 0;
        cyc  = 0;
        set_in(0, 1'b1, {16'h0, ba[0]}, {16'h0, bb[0]}, bm[0]);
        while (nout < 4 && cyc < 200) begin
            if (i16.Out_Valid_Out) begin
                check("b2b_res", get_res(0), be[nout]);
                nout++;
            end
            took = i16.In_Ready_Out && (nin < 4);
            @(posedge clk); @(negedge clk);
            cyc++;
            if (took) begin
                acc_cyc[nin] = cyc;
                nin++;
                if (nin < 4) set_in(0, 1'b1, {16'h0, ba[nin]}, {16'h0, bb[nin]}, bm[nin]);
                else         set_in(0, 1'b0, 32'h0, 32'h0, 1'b0);
            end
        end
        check("b2b_count", 64'(nout), 64'd4);
        for (int i = 1; i < 4; i++)
            check("b2b_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd18);
        @(posedge clk); @(negedge clk);

        // Reset during CALC aborts the operation
        set_in(0, 1'b1, 32'd123, 32'd456, 1'b0);
        @(posedge clk); @(negedge clk);
        set_in(0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (4) begin @(posedge clk); @(negedge clk); end
        check("mid_busy", 64'(i16.In_Ready_Out), 64'd0);
        rst16_n = 1'b0;
        @(posedge clk); @(negedge clk);
        check("mid_rst", {62'b0, i16.In_Ready_Out, i16.Out_Valid_Out}, 64'b10);
        check("mid_rst_res", get_res(0), 64'd0);
        rst16_n = 1'b1;
        run_op(0, 16, 32'd0, 32'hFFFF, 1'b0, 64'd0, "after_rst", 0);

        // Random sweeps at WIDTH 4 and WIDTH 32
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rm = 1'($urandom_range(0, 1));
            run_op(1, 4, ra, rb, rm, model(4, ra, rb, rm), "w4", 0);
        end
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rm = 1'($urandom_range(0, 1));
            run_op(2, 32, ra, rb, rm, model(32, ra, rb, rm), "w32", 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
